// File: rtl/m10k_mat_read.sv
// Reads an M x N matrix out of an M10K block, one row per address, and
// reassembles the rows into a flat matrix bus for the SpMV compute stage.
module m10k_mat_read #(
    parameter int DATA_LEN     = 32,
    parameter int M            = 8,
    parameter int N            = 8,
    parameter int ADDRESS_SIZE = 4,
    parameter int OFFSET       = 0,
    parameter int READ_LATENCY = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic                         i_read_start,
    output logic [ADDRESS_SIZE-1:0]      o_read_addr,
    output logic                         o_read_en,
    input  logic [DATA_LEN*N-1:0]        i_read_data,
    output logic [DATA_LEN*M*N-1:0]      o_out_mat,
    output logic [3:0]                   o_state,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int ROW_W = DATA_LEN * N;
    localparam int CNT_W = $clog2(M) + 1;

    typedef enum logic [3:0] {
        IDLE  = 4'd15,
        ISSUE = 4'd1,
        DRAIN = 4'd2,
        DONE  = 4'd8
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        issue_cnt;
    logic [CNT_W-1:0]        cap_cnt;
    logic [READ_LATENCY-1:0] vld_p;
    logic                    vld_last;
    logic                    start_acc;

    assign start_acc = (state == IDLE) && i_read_start;
    assign vld_last  = vld_p[READ_LATENCY-1];
    assign o_state   = state;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read enable and address are decoded from the state register so a reset
    // pulls them low without waiting for a clock edge.
    always_comb begin
        state_nxt   = state;
        o_read_en   = 1'b0;
        o_read_addr = '0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (state)
            IDLE: begin
                if (i_read_start) state_nxt = ISSUE;
            end
            ISSUE: begin
                o_read_en   = 1'b1;
                o_read_addr = ADDRESS_SIZE'(OFFSET) + ADDRESS_SIZE'(issue_cnt);
                o_busy      = 1'b1;
                if (issue_cnt == CNT_W'(M - 1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                o_busy = 1'b1;
                if (vld_last && (cap_cnt == CNT_W'(M - 1))) state_nxt = DONE;
            end
            DONE: begin
                o_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            issue_cnt <= '0;
            cap_cnt   <= '0;
        end else begin
            if (start_acc) begin
                issue_cnt <= '0;
            end else if (state == ISSUE) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            if (start_acc) begin
                cap_cnt <= '0;
            end else if (vld_last) begin
                cap_cnt <= cap_cnt + CNT_W'(1);
            end
        end
    end

    // Valid pipe mirrors the M10K read latency: bit i is an enable issued i+1 cycles ago.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= o_read_en;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Only the row being captured changes; the rest keep the previous pass.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_out_mat <= '0;
        end else if (vld_last) begin
            for (int r = 0; r < M; r++) begin
                if (cap_cnt == CNT_W'(r)) begin
                    o_out_mat[r*ROW_W +: ROW_W] <= i_read_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_m10k_mat_read.sv
// Bench for m10k_mat_read: M10K memory models plus a row-packing reference.
module tb_m10k_mat_read;

    localparam int DL = 32;
    localparam int M  = 8;
    localparam int N  = 8;
    localparam int AS = 4;
    localparam int RW = DL * N;
    localparam int MW = RW * M;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [RW-1:0] mem [16];

    // Instance A: defaults (latency 1, offset 0)
    logic          rstn_a, start_a, en_a, busy_a, done_a;
    logic [AS-1:0] addr_a;
    logic [RW-1:0] rdata_a;
    logic [MW-1:0] mat_a;
    logic [3:0]    state_a;

    // Instance B: latency 3, offset 4
    logic          rstn_b, start_b, en_b, busy_b, done_b;
    logic [AS-1:0] addr_b;
    logic [RW-1:0] rdata_b;
    logic [MW-1:0] mat_b;
    logic [3:0]    state_b;
    logic [RW-1:0] qb [3];

    m10k_mat_read #(.DATA_LEN(DL), .M(M), .N(N), .ADDRESS_SIZE(AS),
                    .OFFSET(0), .READ_LATENCY(1)) dut_a (
        .i_clk(clk), .i_rstn(rstn_a), .i_read_start(start_a),
        .o_read_addr(addr_a), .o_read_en(en_a), .i_read_data(rdata_a),
        .o_out_mat(mat_a), .o_state(state_a), .o_busy(busy_a), .o_done(done_a));

    m10k_mat_read #(.DATA_LEN(DL), .M(M), .N(N), .ADDRESS_SIZE(AS),
                    .OFFSET(4), .READ_LATENCY(3)) dut_b (
        .i_clk(clk), .i_rstn(rstn_b), .i_read_start(start_b),
        .o_read_addr(addr_b), .o_read_en(en_b), .i_read_data(rdata_b),
        .o_out_mat(mat_b), .o_state(state_b), .o_busy(busy_b), .o_done(done_b));

    // M10K models: registered q, extra output stages for the longer latency
    always @(posedge clk) rdata_a <= en_a ? mem[addr_a] : '0;
    always @(posedge clk) begin
        qb[0] <= en_b ? mem[addr_b] : '0;
        qb[1] <= qb[0];
        qb[2] <= qb[1];
    end
    assign rdata_b = qb[2];

    // Reference: row k of the assembled matrix is the word at OFFSET+k
    function automatic logic [MW-1:0] exp_mat(input int off);
        logic [MW-1:0] m;
        m = '0;
        for (int k = 0; k < M; k++) m[k*RW +: RW] = mem[(off + k) % 16];
        return m;
    endfunction

    task automatic fill_pattern();
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < N; j++) mem[k][j*DL +: DL] = DL'(k * 8 + j);
    endtask

    task automatic fill_random();
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < N; j++) mem[k][j*DL +: DL] = $urandom;
    endtask

    // Leaves the bench in cycle 1 (just after the start edge) of instance A
    task automatic pulse_start_a();
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic test_reset();
        rstn_a = 1'b0; rstn_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        fill_pattern();
        repeat (3) @(negedge clk);
        total++; if (state_a !== 4'd15) begin bad++; $display("FAIL reset_state_a got=%0d want=15", state_a); end
        total++; if (en_a !== 1'b0 || addr_a !== '0) begin bad++; $display("FAIL reset_rd_a en=%b addr=%0d want 0/0", en_a, addr_a); end
        total++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin bad++; $display("FAIL reset_flags_a busy=%b done=%b want 0/0", busy_a, done_a); end
        total++; if (mat_a !== '0) begin bad++; $display("FAIL reset_mat_a got nonzero want 0"); end
        total++; if (state_b !== 4'd15 || en_b !== 1'b0 || mat_b !== '0) begin bad++; $display("FAIL reset_b state=%0d en=%b want 15/0", state_b, en_b); end
        rstn_a = 1'b1; rstn_b = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int ndone;
        logic [MW-1:0] want;
        ndone = 0;
        fill_pattern();
        pulse_start_a();
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (cyc > 1) @(negedge clk);
            total++;
            if (en_a !== (cyc >= 1 && cyc <= M)) begin bad++; $display("FAIL basic_en cyc=%0d got=%b", cyc, en_a); end
            total++;
            if (addr_a !== ((cyc <= M) ? AS'(cyc - 1) : AS'(0))) begin bad++; $display("FAIL basic_addr cyc=%0d got=%0d want=%0d", cyc, addr_a, (cyc <= M) ? cyc - 1 : 0); end
            total++;
            if (done_a !== (cyc == M + 2)) begin bad++; $display("FAIL basic_done cyc=%0d got=%b", cyc, done_a); end
            if (done_a === 1'b1) ndone++;
        end
        want = exp_mat(0);
        total++; if (ndone !== 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", ndone); end
        total++; if (mat_a !== want) begin bad++; $display("FAIL basic_mat got=%h want=%h", mat_a, want); end
        total++; if (mat_a[RW*3 + DL*5 +: DL] !== 32'd29) begin bad++; $display("FAIL basic_r3e5 got=%0d want=29", mat_a[RW*3 + DL*5 +: DL]); end
    endtask

    task automatic test_latency_offset();
        logic [MW-1:0] want;
        fill_random();
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clk);
            start_b = 1'b0;
            total++;
            if (en_b !== (cyc <= M)) begin bad++; $display("FAIL lat_en cyc=%0d got=%b", cyc, en_b); end
            total++;
            if (addr_b !== ((cyc <= M) ? AS'(cyc + 3) : AS'(0))) begin bad++; $display("FAIL lat_addr cyc=%0d got=%0d want=%0d", cyc, addr_b, (cyc <= M) ? cyc + 3 : 0); end
            if (cyc >= M + 1 && cyc <= M + 3) begin
                total++;
                if (state_b !== 4'd2) begin bad++; $display("FAIL lat_drain cyc=%0d got=%0d want=2", cyc, state_b); end
            end
            total++;
            if (done_b !== (cyc == M + 4)) begin bad++; $display("FAIL lat_done cyc=%0d got=%b", cyc, done_b); end
        end
        want = exp_mat(4);
        total++; if (mat_b !== want) begin bad++; $display("FAIL lat_mat got=%h want=%h", mat_b, want); end
    endtask

    task automatic test_back_to_back();
        int ndone, p;
        logic [3:0] ws;
        ndone = 0;
        fill_random();
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 33; cyc++) begin
            @(negedge clk);
            p = (cyc - 1) % (M + 3) + 1;
            ws = (p <= M) ? 4'd1 : (p == M + 1) ? 4'd2 : (p == M + 2) ? 4'd8 : 4'd15;
            total++;
            if (state_a !== ws) begin bad++; $display("FAIL b2b_state cyc=%0d got=%0d want=%0d", cyc, state_a, ws); end
            total++;
            if (en_a !== (p <= M) || done_a !== (p == M + 2)) begin bad++; $display("FAIL b2b_en_done cyc=%0d en=%b done=%b", cyc, en_a, done_a); end
            if (done_a === 1'b1) ndone++;
        end
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (ndone !== 3) begin bad++; $display("FAIL b2b_done_count got=%0d want=3", ndone); end
        total++; if (state_a !== 4'd15) begin bad++; $display("FAIL b2b_idle got=%0d want=15", state_a); end
        total++; if (mat_a !== exp_mat(0)) begin bad++; $display("FAIL b2b_mat got=%h want=%h", mat_a, exp_mat(0)); end
    endtask

    task automatic test_reset_mid();
        int ndone;
        ndone = 0;
        pulse_start_a();
        repeat (4) @(negedge clk);
        #1 rstn_a = 1'b0;
        #1;
        total++; if (en_a !== 1'b0 || addr_a !== '0) begin bad++; $display("FAIL rstmid_rd en=%b addr=%0d want 0/0", en_a, addr_a); end
        total++; if (state_a !== 4'd15) begin bad++; $display("FAIL rstmid_state got=%0d want=15", state_a); end
        total++; if (mat_a !== '0) begin bad++; $display("FAIL rstmid_mat got nonzero want 0"); end
        @(negedge clk);
        rstn_a = 1'b1;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(negedge clk);
            if (done_a === 1'b1) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL rstmid_nodone got=%0d want=0", ndone); end
        total++; if (mat_a !== '0) begin bad++; $display("FAIL rstmid_discard got nonzero want 0"); end
        fill_random();
        pulse_start_a();
        for (int cyc = 2; cyc <= M + 2; cyc++) begin
            @(negedge clk);
            if (done_a === 1'b1) ndone++;
        end
        total++; if (done_a !== 1'b1 || ndone !== 1) begin bad++; $display("FAIL rstmid_fresh_done done=%b count=%0d want 1/1", done_a, ndone); end
        total++; if (mat_a !== exp_mat(0)) begin bad++; $display("FAIL rstmid_fresh_mat got=%h want=%h", mat_a, exp_mat(0)); end
    endtask

    task automatic test_retention();
        logic [MW-1:0] old_mat;
        logic [MW-1:0] new_mat;
        old_mat = exp_mat(0);
        fill_random();
        new_mat = exp_mat(0);
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            total++;
            if (mat_a !== old_mat || state_a !== 4'd15) begin bad++; $display("FAIL retain cyc=%0d state=%0d got=%h want=%h", cyc, state_a, mat_a, old_mat); end
        end
        pulse_start_a();
        @(negedge clk);
        @(negedge clk);
        total++; if (mat_a[0 +: RW] !== new_mat[0 +: RW]) begin bad++; $display("FAIL retain_row0 got=%h want=%h", mat_a[0 +: RW], new_mat[0 +: RW]); end
        total++; if (mat_a[MW-1:RW] !== old_mat[MW-1:RW]) begin bad++; $display("FAIL retain_rows1_7 got=%h want=%h", mat_a[MW-1:RW], old_mat[MW-1:RW]); end
        repeat (M) @(negedge clk);
        total++; if (mat_a !== new_mat) begin bad++; $display("FAIL retain_pass2 got=%h want=%h", mat_a, new_mat); end
    endtask

    task automatic test_roundtrip();
        logic [MW-1:0] ref_mat;
        for (int e = 0; e < M * N; e++) ref_mat[e*DL +: DL] = $urandom;
        for (int k = 0; k < M; k++) mem[k] = ref_mat[k*RW +: RW];
        pulse_start_a();
        repeat (M + 2) @(negedge clk);
        total++; if (state_a !== 4'd15) begin bad++; $display("FAIL rt_idle got=%0d want=15", state_a); end
        total++; if (mat_a !== ref_mat) begin bad++; $display("FAIL rt_mat got=%h want=%h", mat_a, ref_mat); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_latency_offset();
        test_back_to_back();
        test_reset_mid();
        test_retention();
        test_roundtrip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
